// File: rtl/vt52_video_timing.sv
// Parametrised raster timing generator: pixel enable, blank/sync, beam position,
// optional scandoubling. Optional character-cell addressing under VT52_CELL_ADDR_EN.
module vt52_video_timing #(
    parameter int CE_DIV        = 4,
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 64,
    parameter int H_BP          = 80,
    parameter int V_ACTIVE_NTSC = 240,
    parameter int V_TOTAL_NTSC  = 262,
    parameter int V_ACTIVE_PAL  = 288,
    parameter int V_TOTAL_PAL   = 312,
    parameter int V_FP          = 3,
    parameter int V_SYNC        = 3
`ifdef VT52_CELL_ADDR_EN
    ,
    parameter int CHAR_W        = 8,
    parameter int CHAR_H        = 10
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pal,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync,
    output logic [9:0] hcount,
    output logic [8:0] vcount,
    output logic       line_rep,
    output logic       frame_start
`ifdef VT52_CELL_ADDR_EN
    ,
    output logic [6:0] cell_col,
    output logic [4:0] cell_row,
    output logic [3:0] cell_scan
`endif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int DW       = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [DW-1:0] div_last;
    logic          pal_q;
    logic          sd_q;
    logic          ce_now;
    logic          h_wrap;
    logic          v_step;
    logic          v_wrap;
    logic          frame_wrap;
    logic [9:0]    h_nxt;
    logic [8:0]    v_nxt;
    logic          rep_nxt;
    logic [8:0]    v_total;
    logic [8:0]    v_active;
    logic [8:0]    vs_start;
    logic [8:0]    vs_end;
    logic          hb_nxt;
    logic          hs_nxt;
    logic          vb_nxt;
    logic          vs_nxt;

    // Next-position and decode logic; the registers below only commit it on ce.
    always_comb begin
        div_last   = sd_q ? DW'(CE_DIV / 2 - 1) : DW'(CE_DIV - 1);
        ce_now     = (div_q >= div_last);
        div_d      = ce_now ? '0 : div_q + DW'(1);

        v_total    = pal_q ? 9'(V_TOTAL_PAL)  : 9'(V_TOTAL_NTSC);
        v_active   = pal_q ? 9'(V_ACTIVE_PAL) : 9'(V_ACTIVE_NTSC);
        vs_start   = v_active + 9'(V_FP);
        vs_end     = vs_start + 9'(V_SYNC);

        h_wrap     = (hcount == 10'(H_TOTAL - 1));
        h_nxt      = h_wrap ? 10'd0 : hcount + 10'd1;
        // In scandouble a source line advances only after its repeat emission.
        v_step     = h_wrap && (!sd_q || line_rep);
        rep_nxt    = (h_wrap && sd_q) ? ~line_rep : line_rep;
        v_wrap     = v_step && (vcount == v_total - 9'd1);
        frame_wrap = h_wrap && v_wrap;

        v_nxt      = vcount;
        if (v_wrap) begin
            v_nxt = 9'd0;
        end else if (v_step) begin
            v_nxt = vcount + 9'd1;
        end

        hb_nxt     = (h_nxt >= 10'(H_ACTIVE));
        hs_nxt     = (h_nxt >= 10'(HS_START)) && (h_nxt < 10'(HS_END));
        vb_nxt     = (v_nxt >= v_active);
        vs_nxt     = (v_nxt >= vs_start) && (v_nxt < vs_end);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            ce_pix      <= 1'b0;
            frame_start <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            line_rep    <= 1'b0;
            HBlank      <= 1'b0;
            HSync       <= 1'b0;
            VBlank      <= 1'b0;
            VSync       <= 1'b0;
            pal_q       <= pal;
            sd_q        <= scandouble;
        end else begin
            div_q       <= div_d;
            ce_pix      <= ce_now;
            frame_start <= ce_now && frame_wrap;
            // Mode is picked up only at a frame boundary; the new divider applies
            // to the divider cycle already in progress.
            if (frame_start) begin
                pal_q <= pal;
                sd_q  <= scandouble;
            end
            if (ce_now) begin
                hcount   <= h_nxt;
                vcount   <= v_nxt;
                line_rep <= rep_nxt;
                HBlank   <= hb_nxt;
                HSync    <= hs_nxt;
                VBlank   <= vb_nxt;
                VSync    <= vs_nxt;
            end
        end
    end

`ifdef VT52_CELL_ADDR_EN
    localparam int CPW = (CHAR_W > 2) ? $clog2(CHAR_W) : 1;

    logic [CPW-1:0] cell_px;

    // Incremental cell counters; frozen through vertical blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            cell_px   <= '0;
            cell_col  <= '0;
            cell_row  <= '0;
            cell_scan <= '0;
        end else if (ce_now) begin
            if (frame_wrap) begin
                cell_px   <= '0;
                cell_col  <= '0;
                cell_row  <= '0;
                cell_scan <= '0;
            end else if (!vb_nxt) begin
                if (h_wrap) begin
                    cell_px  <= '0;
                    cell_col <= '0;
                    if (v_step) begin
                        if (cell_scan == 4'(CHAR_H - 1)) begin
                            cell_scan <= '0;
                            cell_row  <= cell_row + 5'd1;
                        end else begin
                            cell_scan <= cell_scan + 4'd1;
                        end
                    end
                end else if (cell_px == CPW'(CHAR_W - 1)) begin
                    cell_px  <= '0;
                    cell_col <= cell_col + 7'd1;
                end else begin
                    cell_px <= cell_px + CPW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vt52_video_timing.sv
// Directed bench for vt52_video_timing: vector table plus hand-written sequences
// for mode changes and mid-frame reset.
module tb_vt52_video_timing;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pal = 1'b0;
    logic       scandouble = 1'b0;
    logic       ce_pix;
    logic       HBlank;
    logic       HSync;
    logic       VBlank;
    logic       VSync;
    logic [9:0] hcount;
    logic [8:0] vcount;
    logic       line_rep;
    logic       frame_start;
`ifdef VT52_CELL_ADDR_EN
    logic [6:0] cell_col;
    logic [4:0] cell_row;
    logic [3:0] cell_scan;
`endif

    vt52_video_timing #(
        .CE_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE_NTSC(4), .V_TOTAL_NTSC(8), .V_ACTIVE_PAL(6), .V_TOTAL_PAL(10),
        .V_FP(1), .V_SYNC(1)
`ifdef VT52_CELL_ADDR_EN
        , .CHAR_W(4), .CHAR_H(2)
`endif
    ) dut (
        .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble),
        .ce_pix(ce_pix), .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
        .hcount(hcount), .vcount(vcount), .line_rep(line_rep), .frame_start(frame_start)
`ifdef VT52_CELL_ADDR_EN
        , .cell_col(cell_col), .cell_row(cell_row), .cell_scan(cell_scan)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst; bit p; bit s; int k;
        bit ce; int h; int v; bit rep; bit hb; bit hs; bit vb; bit vs; bit fs;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   kcnt  = 0;

    function automatic vec_t mk(bit rst, bit p, bit s, int k, bit ce, int h, int v,
                                bit rep, bit hb, bit hs, bit vb, bit vs, bit fs);
        vec_t r;
        r.rst = rst; r.p = p; r.s = s; r.k = k; r.ce = ce; r.h = h; r.v = v;
        r.rep = rep; r.hb = hb; r.hs = hs; r.vb = vb; r.vs = vs; r.fs = fs;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic p, input logic s);
        pal = p;
        scandouble = s;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        kcnt = 0;
    endtask

    task automatic advance_to(input int k);
        while (kcnt < k) begin
            step();
            kcnt++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (clk %0d after reset)", name, act, exp, kcnt);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        check({tag, " ce_pix"}, int'(ce_pix), int'(e.ce));
        check({tag, " hcount"}, int'(hcount), e.h);
        check({tag, " vcount"}, int'(vcount), e.v);
        check({tag, " line_rep"}, int'(line_rep), int'(e.rep));
        check({tag, " HBlank"}, int'(HBlank), int'(e.hb));
        check({tag, " HSync"}, int'(HSync), int'(e.hs));
        check({tag, " VBlank"}, int'(VBlank), int'(e.vb));
        check({tag, " VSync"}, int'(VSync), int'(e.vs));
        check({tag, " frame_start"}, int'(frame_start), int'(e.fs));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              rst p  s  clk   ce h   v  rep hb hs vb vs fs
        vecs.push_back(mk(1, 0, 0,   0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   3, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   4, 1,  1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   5, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  40, 1, 10, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  44, 1, 11, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  48, 1, 12, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  64, 1,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 256, 1,  0, 4, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 332, 1,  3, 5, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 384, 1,  0, 6, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 508, 1, 15, 7, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 512, 1,  0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 513, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        // PAL
        vecs.push_back(mk(1, 1, 0,   0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 384, 1,  0, 6, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 456, 1,  2, 7, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 512, 1,  0, 8, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 636, 1, 15, 9, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 640, 1,  0, 0, 0, 0, 0, 0, 0, 1));
        // scandouble NTSC
        vecs.push_back(mk(1, 0, 1,   1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1,   2, 1,  1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1,  20, 1, 10, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1,  32, 1,  0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1,  64, 1,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 320, 1,  0, 5, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 352, 1,  0, 5, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 382, 1, 15, 5, 1, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 384, 1,  0, 6, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 512, 1,  0, 0, 0, 0, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset(vecs[i].p, vecs[i].s);
            advance_to(vecs[i].k);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // PAL request mid-frame: current NTSC frame completes, next one is PAL.
        do_reset(1'b0, 1'b0);
        advance_to(148);
        check("pal_chg pos h", int'(hcount), 5);
        check("pal_chg pos v", int'(vcount), 2);
        pal = 1'b1;
        advance_to(336);
        check("pal_chg old vsync", int'(VSync), 1);
        check("pal_chg old v", int'(vcount), 5);
        advance_to(512);
        check("pal_chg end1 fs", int'(frame_start), 1);
        check("pal_chg end1 v", int'(vcount), 0);
        advance_to(960);
        check("pal_chg new vsync", int'(VSync), 1);
        check("pal_chg new v", int'(vcount), 7);
        advance_to(1024);
        check("pal_chg no fs", int'(frame_start), 0);
        check("pal_chg v8", int'(vcount), 8);
        advance_to(1152);
        check("pal_chg end2 fs", int'(frame_start), 1);

        // One-clock reset mid-frame.
        do_reset(1'b0, 1'b0);
        advance_to(292);
        check("rst_mid pre h", int'(hcount), 9);
        check("rst_mid pre vb", int'(VBlank), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        kcnt = 0;
        check_all("rst_mid post", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        advance_to(3);
        check("rst_mid k3 ce", int'(ce_pix), 0);
        advance_to(4);
        check("rst_mid k4 ce", int'(ce_pix), 1);
        check("rst_mid k4 h", int'(hcount), 1);

        // Scandouble request mid-frame: divider changes after frame_start.
        do_reset(1'b0, 1'b0);
        advance_to(100);
        scandouble = 1'b1;
        advance_to(102);
        check("sd_chg k102 ce", int'(ce_pix), 0);
        advance_to(512);
        check("sd_chg fs", int'(frame_start), 1);
        advance_to(513);
        check("sd_chg k513 ce", int'(ce_pix), 0);
        advance_to(514);
        check("sd_chg k514 ce", int'(ce_pix), 1);
        check("sd_chg k514 h", int'(hcount), 1);
        advance_to(515);
        check("sd_chg k515 ce", int'(ce_pix), 0);
        advance_to(516);
        check("sd_chg k516 ce", int'(ce_pix), 1);
        check("sd_chg k516 h", int'(hcount), 2);

`ifdef VT52_CELL_ADDR_EN
        do_reset(1'b0, 1'b0);
        for (int p = 0; p < 16; p++) begin
            advance_to(4 * p);
            check($sformatf("cell_col p%0d", p), int'(cell_col), p / 4);
        end
        advance_to(64);
        check("cell line1 scan", int'(cell_scan), 1);
        check("cell line1 row", int'(cell_row), 0);
        advance_to(128);
        check("cell line2 scan", int'(cell_scan), 0);
        check("cell line2 row", int'(cell_row), 1);
        advance_to(212);
        check("cell line3 col", int'(cell_col), 1);
        check("cell line3 scan", int'(cell_scan), 1);
        advance_to(356);
        check("cell vblank col", int'(cell_col), 3);
        check("cell vblank row", int'(cell_row), 1);
        check("cell vblank scan", int'(cell_scan), 1);
        advance_to(512);
        check("cell fs col", int'(cell_col), 0);
        check("cell fs row", int'(cell_row), 0);
        check("cell fs scan", int'(cell_scan), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
